// File: rtl/breakout_game_ctrl_if.sv
// breakout_game_ctrl_if
// Bundles the signals exchanged between the breakout game engine and the VGA
// renderer.
//   hor_count, ver_count   : renderer scan counters (renderer -> engine)
//   paddle_pos             : paddle left edge         (engine -> renderer)
//   ball_x, ball_y         : ball top-left corner     (engine -> renderer)
//   lives, game_state      : game status              (engine -> renderer)
//   frame_tick             : one-cycle frame update pulse (engine -> renderer)
// Modport master is the game engine view, slave is the renderer view.
interface breakout_game_ctrl_if;
  logic [9:0] hor_count;
  logic [9:0] ver_count;
  logic [9:0] paddle_pos;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] lives;
  logic [1:0] game_state;
  logic       frame_tick;

  modport master (
    input  hor_count, ver_count,
    output paddle_pos, ball_x, ball_y, lives, game_state, frame_tick
  );

  modport slave (
    output hor_count, ver_count,
    input  paddle_pos, ball_x, ball_y, lives, game_state, frame_tick
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl
// Game-state engine for a breakout game, sitting directly upstream of the VGA
// renderer. Once per video frame (detected from the renderer's scan counters
// inside vertical blanking) it moves the paddle from the buttons, steps the
// ball, resolves wall and paddle bounces and runs the serve/play/miss/over
// state machine with a life counter.
// Ports:
//   CLK_25MH   : pixel clock shared with the renderer
//   reset      : asynchronous active-low reset
//   btn_left   : move paddle left (asynchronous, synchronized here)
//   btn_right  : move paddle right (asynchronous, synchronized here)
//   btn_launch : serve the ball (asynchronous, synchronized here)
//   vid        : renderer interface (scan counters in, positions/status out)
module breakout_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 7,
  parameter int PADDLE_W    = 100,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int LIVES_INIT  = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic                 CLK_25MH,
  input  logic                 reset,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_launch,
  breakout_game_ctrl_if.master vid
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [9:0] PADDLE_MAX  = 10'(SCREEN_W - PADDLE_W);
  localparam logic [9:0] PADDLE_INIT = 10'((SCREEN_W - PADDLE_W) / 2);
  // Horizontal offset that centres the ball on the paddle.
  localparam logic [9:0] SERVE_OFS   = 10'((PADDLE_W - BALL_SIZE - 1) / 2);
  // Ball row resting on top of the paddle.
  localparam logic [9:0] SERVE_Y     = 10'(PADDLE_Y - BALL_SIZE - 1);
  localparam logic [9:0] BALL_X_MAX  = 10'(SCREEN_W - 1 - BALL_SIZE);
  localparam logic [9:0] BALL_Y_MAX  = 10'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [9:0] TICK_ROW    = 10'(SCREEN_H);
  localparam logic [9:0] STEP        = 10'(PADDLE_STEP);
  localparam logic [9:0] SPEED       = 10'(BALL_SPEED);
  localparam logic [9:0] BSIZE       = 10'(BALL_SIZE);
  localparam logic [9:0] PADDLE_TOP  = 10'(PADDLE_Y);
  localparam logic [9:0] PADDLE_SPAN = 10'(PADDLE_W - 1);
  localparam logic [1:0] LIVES_START = 2'(LIVES_INIT);
  localparam int         CNT_W       = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [9:0]       paddle_q, paddle_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [1:0]       lives_q, lives_d;
  logic             dir_right_q, dir_right_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             frame_tick_q;

  logic [1:0] sync_left, sync_right, sync_launch;
  logic       left_req, right_req, launch_req;
  logic       tick;

  // Sums are formed one bit wider than the positions so they can never wrap
  // before being compared against the limits.
  logic [10:0] paddle_inc, paddle_last;
  logic [10:0] ball_x_inc, ball_right;
  logic [10:0] ball_y_inc, ball_bottom, next_bottom;
  logic        paddle_hit;

  // The renderer's counters hit this point exactly once per frame, inside
  // vertical blanking, so updates never disturb the visible area.
  assign tick = (vid.hor_count == 10'd0) && (vid.ver_count == TICK_ROW);

  assign left_req   = sync_left[1];
  assign right_req  = sync_right[1];
  assign launch_req = sync_launch[1];

  assign paddle_inc  = {1'b0, paddle_q} + {1'b0, STEP};
  assign paddle_last = {1'b0, paddle_q} + {1'b0, PADDLE_SPAN};
  assign ball_x_inc  = {1'b0, ball_x_q} + {1'b0, SPEED};
  assign ball_right  = {1'b0, ball_x_q} + {1'b0, BSIZE};
  assign ball_y_inc  = {1'b0, ball_y_q} + {1'b0, SPEED};
  assign ball_bottom = {1'b0, ball_y_q} + {1'b0, BSIZE};
  assign next_bottom = ball_y_inc + {1'b0, BSIZE};

  // A hit needs the ball bottom to cross the paddle's top row on this step
  // while overlapping the paddle horizontally, judged on pre-tick positions.
  assign paddle_hit = (ball_bottom < {1'b0, PADDLE_TOP}) &&
                      (next_bottom >= {1'b0, PADDLE_TOP}) &&
                      (ball_right >= {1'b0, paddle_q}) &&
                      ({1'b0, ball_x_q} <= paddle_last);

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      sync_left   <= 2'b00;
      sync_right  <= 2'b00;
      sync_launch <= 2'b00;
    end else begin
      sync_left   <= {sync_left[0], btn_left};
      sync_right  <= {sync_right[0], btn_right};
      sync_launch <= {sync_launch[0], btn_launch};
    end
  end

  // Game state register; the next-state logic only changes values on a tick.
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      state_q      <= SERVE;
      paddle_q     <= PADDLE_INIT;
      ball_x_q     <= PADDLE_INIT + SERVE_OFS;
      ball_y_q     <= SERVE_Y;
      lives_q      <= LIVES_START;
      dir_right_q  <= 1'b1;
      dir_up_q     <= 1'b1;
      miss_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      paddle_q     <= paddle_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      lives_q      <= lives_d;
      dir_right_q  <= dir_right_d;
      dir_up_q     <= dir_up_d;
      miss_cnt_q   <= miss_cnt_d;
      frame_tick_q <= tick;
    end
  end

  // Per-frame update: paddle first, then the state-dependent ball handling,
  // which may use the freshly moved paddle when the ball sits on it.
  always_comb begin
    state_d     = state_q;
    paddle_d    = paddle_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    lives_d     = lives_q;
    dir_right_d = dir_right_q;
    dir_up_d    = dir_up_q;
    miss_cnt_d  = miss_cnt_q;

    if (tick && (state_q != OVER)) begin
      if (left_req && !right_req) begin
        paddle_d = (paddle_q < STEP) ? 10'd0 : paddle_q - STEP;
      end else if (right_req && !left_req) begin
        paddle_d = (paddle_inc > {1'b0, PADDLE_MAX}) ? PADDLE_MAX : paddle_inc[9:0];
      end

      case (state_q)
        SERVE: begin
          ball_x_d = paddle_d + SERVE_OFS;
          ball_y_d = SERVE_Y;
          if (launch_req) begin
            state_d     = PLAY;
            dir_right_d = 1'b1;
            dir_up_d    = 1'b1;
          end
        end

        PLAY: begin
          // Horizontal and vertical motion resolve independently, so a
          // corner hit flips both directions on the same frame.
          if (dir_right_q) begin
            if (ball_x_inc > {1'b0, BALL_X_MAX}) begin
              ball_x_d    = BALL_X_MAX;
              dir_right_d = 1'b0;
            end else begin
              ball_x_d = ball_x_inc[9:0];
            end
          end else begin
            if (ball_x_q < SPEED) begin
              ball_x_d    = 10'd0;
              dir_right_d = 1'b1;
            end else begin
              ball_x_d = ball_x_q - SPEED;
            end
          end

          if (dir_up_q) begin
            if (ball_y_q < SPEED) begin
              ball_y_d = 10'd0;
              dir_up_d = 1'b0;
            end else begin
              ball_y_d = ball_y_q - SPEED;
            end
          end else if (paddle_hit) begin
            ball_y_d = SERVE_Y;
            dir_up_d = 1'b1;
          end else if (ball_y_inc > {1'b0, BALL_Y_MAX}) begin
            ball_y_d = BALL_Y_MAX;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = MISS;
            end
          end else begin
            ball_y_d = ball_y_inc[9:0];
          end
        end

        MISS: begin
          if (miss_cnt_q == MISS_LAST) begin
            miss_cnt_d = '0;
            state_d    = SERVE;
            ball_x_d   = paddle_d + SERVE_OFS;
            ball_y_d   = SERVE_Y;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign vid.paddle_pos = paddle_q;
  assign vid.ball_x     = ball_x_q;
  assign vid.ball_y     = ball_y_q;
  assign vid.lives      = lives_q;
  assign vid.game_state = state_q;
  assign vid.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl
// Self-checking bench for breakout_game_ctrl. Frames are compressed: the scan
// counters sit at a non-tick value for three clocks and then present the tick
// position (hor=0, ver=480) for one clock. Short directed vectors come from a
// table; multi-frame corner cases are hand-written sequences with
// hand-computed checkpoints.
module tb_breakout_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic btn_left;
  logic btn_right;
  logic btn_launch;

  int compared    = 0;
  int mismatched  = 0;
  int pulse_count = 0;

  breakout_game_ctrl_if vid ();

  breakout_game_ctrl dut (
    .CLK_25MH   (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_launch (btn_launch),
    .vid        (vid)
  );

  always #5 clk = ~clk;

  // Count frame_tick pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (vid.frame_tick) pulse_count <= pulse_count + 1;
  end

  typedef struct packed {
    logic       l;
    logic       r;
    logic       la;
    logic [9:0] p;
    logic [9:0] bx;
    logic [9:0] by;
    logic [1:0] lv;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [11];

  task automatic check_output(input string name, input logic [9:0] p, input logic [9:0] bx,
                              input logic [9:0] by, input logic [1:0] lv, input logic [1:0] st,
                              input logic chk_ft, input logic ft);
    compared++;
    if ((vid.paddle_pos !== p) || (vid.ball_x !== bx) || (vid.ball_y !== by) ||
        (vid.lives !== lv) || (vid.game_state !== st) ||
        (chk_ft && (vid.frame_tick !== ft))) begin
      mismatched++;
      $display("[TB] FAIL %s: got paddle=%0d ball=(%0d,%0d) lives=%0d state=%0d tick=%0b, expected paddle=%0d ball=(%0d,%0d) lives=%0d state=%0d tick=%0b",
               name, vid.paddle_pos, vid.ball_x, vid.ball_y, vid.lives, vid.game_state,
               vid.frame_tick, p, bx, by, lv, st, ft);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One compressed frame; called on a negedge, returns on the negedge right
  // after the tick edge so the updated outputs can be sampled.
  task automatic apply_frame(input logic l, input logic r, input logic la);
    btn_left      = l;
    btn_right     = r;
    btn_launch    = la;
    vid.hor_count = 10'd5;
    vid.ver_count = 10'd100;
    repeat (3) @(negedge clk);
    vid.hor_count = 10'd0;
    vid.ver_count = 10'd480;
    @(negedge clk);
    vid.hor_count = 10'd1;
    vid.ver_count = 10'd480;
  endtask

  task automatic run_frames(input int n, input logic l, input logic r, input logic la);
    for (int i = 0; i < n; i++) apply_frame(l, r, la);
  endtask

  task automatic do_reset();
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_launch = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'd270, 10'd316, 10'd432, 2'd3, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'd274, 10'd320, 10'd432, 2'd3, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10'd278, 10'd324, 10'd432, 2'd3, 2'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 10'd278, 10'd324, 10'd432, 2'd3, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'd274, 10'd320, 10'd432, 2'd3, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'd270, 10'd316, 10'd432, 2'd3, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 10'd270, 10'd316, 10'd432, 2'd3, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'd270, 10'd318, 10'd430, 2'd3, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'd274, 10'd320, 10'd428, 2'd3, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'd270, 10'd322, 10'd426, 2'd3, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10'd270, 10'd324, 10'd424, 2'd3, 2'd1};

    reset         = 1'b0;
    btn_left      = 1'b0;
    btn_right     = 1'b0;
    btn_launch    = 1'b0;
    vid.hor_count = 10'd1;
    vid.ver_count = 10'd0;
    repeat (3) @(negedge clk);
    check_output("reset held", 10'd270, 10'd316, 10'd432, 2'd3, 2'd0, 1'b1, 1'b0);
    reset = 1'b1;

    // Counter values next to the tick position must not trigger an update.
    btn_right     = 1'b1;
    vid.hor_count = 10'd0;
    vid.ver_count = 10'd479;
    repeat (3) @(negedge clk);
    vid.hor_count = 10'd1;
    vid.ver_count = 10'd480;
    @(negedge clk);
    vid.hor_count = 10'd0;
    vid.ver_count = 10'd481;
    @(negedge clk);
    vid.hor_count = 10'd799;
    vid.ver_count = 10'd480;
    @(negedge clk);
    check_output("near-tick counts", 10'd270, 10'd316, 10'd432, 2'd3, 2'd0, 1'b1, 1'b0);
    check_int("pulses before tick", pulse_count, 0);

    for (int i = 0; i < 11; i++) begin
      apply_frame(vecs[i].l, vecs[i].r, vecs[i].la);
      check_output($sformatf("vector %0d", i), vecs[i].p, vecs[i].bx, vecs[i].by,
                   vecs[i].lv, vecs[i].st, 1'b1, 1'b1);
    end
    @(negedge clk);
    check_int("tick pulse count", pulse_count, 11);
    check_output("tick low between", 10'd270, 10'd324, 10'd424, 2'd3, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    reset = 1'b0;
    #1;
    check_output("async reset", 10'd270, 10'd316, 10'd432, 2'd3, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Paddle clamping at both walls.
    run_frames(67, 1'b0, 1'b1, 1'b0);
    check_output("right 67", 10'd538, 10'd584, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b1, 1'b0);
    check_output("right clamp", 10'd540, 10'd586, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(12, 1'b0, 1'b1, 1'b0);
    check_output("right held", 10'd540, 10'd586, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(134, 1'b1, 1'b0, 1'b0);
    check_output("left 134", 10'd4, 10'd50, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(1, 1'b1, 1'b0, 1'b0);
    check_output("left to zero", 10'd0, 10'd46, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(65, 1'b1, 1'b0, 1'b0);
    check_output("left held", 10'd0, 10'd46, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    do_reset();
    check_output("reset again", 10'd270, 10'd316, 10'd432, 2'd3, 2'd0, 1'b1, 1'b0);
    run_frames(67, 1'b1, 1'b0, 1'b0);
    check_output("left 67", 10'd2, 10'd48, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);
    run_frames(1, 1'b1, 1'b0, 1'b0);
    check_output("left clamp", 10'd0, 10'd46, 10'd432, 2'd3, 2'd0, 1'b1, 1'b1);

    // Launch, right wall, top wall and a paddle hit.
    do_reset();
    apply_frame(1'b0, 1'b0, 1'b1);
    check_output("launch", 10'd270, 10'd316, 10'd432, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b1, 1'b0, 1'b0);
    check_output("play k1", 10'd266, 10'd318, 10'd430, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(44, 1'b1, 1'b0, 1'b0);
    check_output("play k45", 10'd90, 10'd406, 10'd342, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(113, 1'b0, 1'b0, 1'b0);
    check_output("right wall reach", 10'd90, 10'd632, 10'd116, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("right wall flip", 10'd90, 10'd632, 10'd114, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("moving left", 10'd90, 10'd630, 10'd112, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(56, 1'b0, 1'b0, 1'b0);
    check_output("top wall reach", 10'd90, 10'd518, 10'd0, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("top wall flip", 10'd90, 10'd516, 10'd0, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("top wall bounce", 10'd90, 10'd514, 10'd2, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(215, 1'b0, 1'b0, 1'b0);
    check_output("before hit", 10'd90, 10'd84, 10'd432, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("paddle hit", 10'd90, 10'd82, 10'd432, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("after hit", 10'd90, 10'd80, 10'd430, 2'd3, 2'd1, 1'b1, 1'b1);

    // Near miss at the paddle edge, three misses and game over.
    do_reset();
    apply_frame(1'b0, 1'b0, 1'b1);
    run_frames(44, 1'b1, 1'b0, 1'b0);
    check_output("B k44", 10'd94, 10'd404, 10'd344, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(389, 1'b0, 1'b0, 1'b0);
    check_output("B k433", 10'd94, 10'd84, 10'd432, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("edge no hit", 10'd94, 10'd82, 10'd434, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(19, 1'b0, 1'b0, 1'b0);
    check_output("bottom reach", 10'd94, 10'd44, 10'd472, 2'd3, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("miss 1", 10'd94, 10'd42, 10'd472, 2'd2, 2'd2, 1'b1, 1'b1);
    run_frames(59, 1'b0, 1'b0, 1'b0);
    check_output("miss wait", 10'd94, 10'd42, 10'd472, 2'd2, 2'd2, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("serve after miss 1", 10'd94, 10'd140, 10'd432, 2'd2, 2'd0, 1'b1, 1'b1);
    apply_frame(1'b0, 1'b0, 1'b1);
    check_output("relaunch 2", 10'd94, 10'd140, 10'd432, 2'd2, 2'd1, 1'b1, 1'b1);
    run_frames(453, 1'b0, 1'b0, 1'b0);
    check_output("B2 j453", 10'd94, 10'd220, 10'd472, 2'd2, 2'd1, 1'b1, 1'b1);
    run_frames(1, 1'b0, 1'b0, 1'b0);
    check_output("miss 2", 10'd94, 10'd218, 10'd472, 2'd1, 2'd2, 1'b1, 1'b1);
    run_frames(60, 1'b0, 1'b0, 1'b0);
    check_output("serve after miss 2", 10'd94, 10'd140, 10'd432, 2'd1, 2'd0, 1'b1, 1'b1);
    apply_frame(1'b0, 1'b0, 1'b1);
    run_frames(454, 1'b0, 1'b0, 1'b0);
    check_output("game over", 10'd94, 10'd218, 10'd472, 2'd0, 2'd3, 1'b1, 1'b1);

    run_frames(3, 1'b0, 1'b1, 1'b0);
    check_output("over right", 10'd94, 10'd218, 10'd472, 2'd0, 2'd3, 1'b0, 1'b0);
    run_frames(3, 1'b1, 1'b0, 1'b0);
    check_output("over left", 10'd94, 10'd218, 10'd472, 2'd0, 2'd3, 1'b0, 1'b0);
    run_frames(3, 1'b0, 1'b1, 1'b1);
    check_output("over launch", 10'd94, 10'd218, 10'd472, 2'd0, 2'd3, 1'b0, 1'b0);
    do_reset();
    check_output("reset from over", 10'd270, 10'd316, 10'd432, 2'd3, 2'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
- Game-state engine directly upstream of the VGA renderer; produces the `paddle_pos`, `ball_x` and `ball_y` that the renderer draws.
- Advances exactly once per video frame, using the renderer's `hor_count`/`ver_count` to detect frame timing.
- Handles paddle motion from buttons, ball motion, and wall and paddle bounces.
- Tracks serve, play, miss and game-over through a state machine with a life counter.

Parameters:
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- BALL_SIZE, 7: ball extent beyond its origin; the ball spans x..x+7.
- PADDLE_W, 100: paddle width in pixels.
- PADDLE_Y, 440: top row of the paddle.
- PADDLE_STEP, 4: paddle movement per frame, in pixels.
- BALL_SPEED, 2: ball movement per frame on each axis, in pixels.
- LIVES_INIT, 3: lives granted at reset.
- MISS_FRAMES, 60: frames spent in MISS before the next serve.

Ports:
- CLK_25MH  in  1  pixel clock, shared with the renderer.
- reset  in  1  asynchronous, active-low reset; asserted while 0.
- hor_count  in  10  renderer horizontal counter.
- ver_count  in  10  renderer vertical counter.
- btn_left  in  1  move paddle left; asynchronous.
- btn_right  in  1  move paddle right; asynchronous.
- btn_launch  in  1  serve the ball; asynchronous.
- paddle_pos  out  10  paddle left edge.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- lives  out  2  remaining lives.
- game_state  out  2  0=SERVE, 1=PLAY, 2=MISS, 3=OVER.
- frame_tick  out  1  one-cycle pulse when the frame update occurs.

Behaviour:
- **Reset (reset=0, async):**
  - paddle_pos=270, ball_x=316 (paddle_pos+46), ball_y=432 (PADDLE_Y-BALL_SIZE-1).
  - lives=3, game_state=SERVE, dir_x=right, dir_y=up.
  - miss counter=0, frame_tick=0, synchronizer flops=0.
- **Button synchronization:** every button passes through a 2-flop synchronizer. Only synchronized values are used, sampled on the tick edge.
- **Frame tick:**
  - tick = (hor_count==0 && ver_count==SCREEN_H). This is true for exactly one clock per frame, inside vertical blanking.
  - All state updates happen at the clock edge where tick is true; frame_tick is registered high for that one cycle.
  - No updates occur between ticks, so outputs are stable throughout the visible area.
- **Paddle (every tick, all states except OVER):**
  - left only: paddle_pos = (paddle_pos<PADDLE_STEP) ? 0 : paddle_pos-PADDLE_STEP.
  - right only: paddle_pos = min(paddle_pos+PADDLE_STEP, SCREEN_W-PADDLE_W), i.e. clamped at 540.
  - both or neither pressed: no move.
- **SERVE:**
  - The ball tracks the paddle: ball_x = new paddle_pos+46, ball_y=432.
  - Launch pressed at tick → PLAY with dir_x=right, dir_y=up. The ball does not move on that tick.
- **PLAY (ball step per tick):**
  - X moving left: if ball_x<BALL_SPEED then ball_x=0, dir_x=right; else ball_x-=BALL_SPEED.
  - X moving right: if ball_x+BALL_SPEED > SCREEN_W-1-BALL_SIZE (632) then ball_x=632, dir_x=left; else ball_x+=BALL_SPEED.
  - Y moving up: if ball_y<BALL_SPEED then ball_y=0, dir_y=down; else ball_y-=BALL_SPEED.
  - Y moving down, paddle hit: current bottom (ball_y+BALL_SIZE) < PADDLE_Y, and next bottom ≥ PADDLE_Y, and horizontal overlap (ball_x+BALL_SIZE ≥ paddle_pos && ball_x ≤ paddle_pos+PADDLE_W-1). Result: ball_y=432, dir_y=up.
    - Overlap uses the pre-tick paddle_pos and the pre-tick ball_x.
  - Y moving down, miss: next ball_y > SCREEN_H-1-BALL_SIZE (472) → ball_y=472, lives-=1, go to MISS.
    - If lives was 1, go to OVER instead and lives becomes 0.
  - Y moving down, otherwise: ball_y+=BALL_SPEED.
  - X and Y resolve independently in the same tick. A corner hit flips both directions.
- **MISS:**
  - Ball frozen; the counter increments once per tick.
  - When the counter reaches MISS_FRAMES-1: counter=0, state→SERVE, ball snaps to the paddle.
- **OVER:**
  - Everything frozen. Only reset leaves this state.
- **Arithmetic:** all arithmetic is 11-bit internally so no sum wraps. Outputs never exceed 632 (x) or 472 (y).
- **Reset mid-frame:** immediately returns to the reset values. The next tick starts from those values.

Test Plan:
1. **Reset values:** reset=0, then release; run 1 frame with no buttons → paddle_pos=270, ball_x=316, ball_y=432, lives=3, game_state=0, and exactly one frame_tick pulse per 800×525 clocks.
2. **Paddle clamping:** btn_right held 80 frames → paddle_pos saturates at 540, ball_x=586 in SERVE. Then btn_left held 200 frames → paddle_pos=0, ball_x=46.
3. **Launch and top wall:** launch at paddle_pos=270 → next tick ball at (318,430). Continue until ball_y reaches 0 → dir_y flips and the next tick gives ball_y=2.
4. **Right wall:** force ball_x=631 moving right → ball_x=632 and dir_x=left; next tick ball_x=630.
5. **Paddle hit:** paddle_pos=300, ball (320,431) moving down → ball_y=432, dir_y=up. Same case with paddle_pos=100 → ball_y=433 (no hit).
6. **Miss and game over:** allow 3 misses, each followed by MISS for 60 ticks. After miss 1: lives=2, state=2, and SERVE returns exactly 60 ticks later. After miss 3: lives=0, state=3, and outputs stay frozen under button activity until reset.
